// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcode/funct encodings,
// the control FSM state type and the ALU control type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef logic [2:0] alu_ctl_t;
  localparam alu_ctl_t ALU_AND = 3'b000;
  localparam alu_ctl_t ALU_OR  = 3'b001;
  localparam alu_ctl_t ALU_ADD = 3'b010;
  localparam alu_ctl_t ALU_SUB = 3'b110;
  localparam alu_ctl_t ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, ADDIEX, IMMWB, BRANCH, JUMP, TRAP
  } state_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic alu_ctl_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU.
//   a, b     : operands
//   alu_ctl  : operation select (and/or/add/sub/slt)
//   y        : result (wrapping two's complement, slt is signed)
//   zero     : y == 0
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctl_t    alu_ctl,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = '0;
    case (alu_ctl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: one ALU, one unified memory port with a ready
// handshake, and a control FSM.
//   clk, reset            : clock, asynchronous active-high reset
//   mem_req/mem_we        : request valid / write select
//   mem_addr/mem_wdata    : word-aligned byte address / store data
//   mem_ready/mem_rdata   : transfer completes on edge with req && ready
//   pc                    : current PC (debug)
//   trap                  : high in TRAP (illegal opcode or funct)
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          EXT_OPS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        trap
);

  state_t      state, state_nx;
  logic [31:0] pc_r, ir, mdr, a_r, b_r, aluout;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext, zext;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign sext  = {{16{ir[15]}}, ir[15:0]};
  assign zext  = {16'h0000, ir[15:0]};

  logic [31:0] alu_a, alu_b, alu_y;
  alu_ctl_t    alu_ctl;
  logic        alu_zero, aluout_en, br_take;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  mips_alu u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .alu_ctl (alu_ctl),
    .y       (alu_y),
    .zero    (alu_zero)
  );

  assign br_take = (op == OP_BNE) ? !alu_zero : alu_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  // ALUOut is only loaded in the states that compute something, so the
  // address it drives stays stable through MEMRD/MEMWR wait cycles.
  always_comb begin
    state_nx  = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctl   = ALU_ADD;
    aluout_en = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    case (state)
      FETCH:  if (mem_ready) state_nx = DECODE;
      DECODE: begin
        alu_a     = pc_r;
        alu_b     = {sext[29:0], 2'b00};
        aluout_en = 1'b1;
        case (op)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_RTYPE:     state_nx = funct_legal(funct) ? EXEC : TRAP;
          OP_BEQ:       state_nx = BRANCH;
          OP_BNE:       state_nx = EXT_OPS ? BRANCH : TRAP;
          OP_ADDI:      state_nx = ADDIEX;
          OP_ORI:       state_nx = EXT_OPS ? ADDIEX : TRAP;
          OP_J:         state_nx = JUMP;
          default:      state_nx = TRAP;
        endcase
      end
      MEMADR: begin
        alu_a     = a_r;
        alu_b     = sext;
        aluout_en = 1'b1;
        state_nx  = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD:  if (mem_ready) state_nx = MEMWB;
      MEMWB: begin
        rf_we    = 1'b1;
        rf_wa    = rt;
        rf_wd    = mdr;
        state_nx = FETCH;
      end
      MEMWR:  if (mem_ready) state_nx = FETCH;
      EXEC: begin
        alu_a     = a_r;
        alu_b     = b_r;
        alu_ctl   = funct_to_alu(funct);
        aluout_en = 1'b1;
        state_nx  = ALUWB;
      end
      ALUWB: begin
        rf_we    = 1'b1;
        rf_wa    = rd;
        rf_wd    = aluout;
        state_nx = FETCH;
      end
      ADDIEX: begin
        alu_a     = a_r;
        alu_b     = (op == OP_ORI) ? zext : sext;
        alu_ctl   = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        aluout_en = 1'b1;
        state_nx  = IMMWB;
      end
      IMMWB: begin
        rf_we    = 1'b1;
        rf_wa    = rt;
        rf_wd    = aluout;
        state_nx = FETCH;
      end
      BRANCH: begin
        alu_a    = a_r;
        alu_b    = b_r;
        alu_ctl  = ALU_SUB;
        state_nx = FETCH;
      end
      JUMP:    state_nx = FETCH;
      TRAP:    state_nx = TRAP;
      default: state_nx = TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r   <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      aluout <= '0;
      rf     <= '{default: '0};
    end else begin
      if (state == FETCH && mem_ready) begin
        ir   <= mem_rdata;
        pc_r <= pc_r + 32'd4;
      end
      if (state == MEMRD && mem_ready) mdr <= mem_rdata;
      if (state == DECODE) begin
        a_r <= rf[rs];
        b_r <= rf[rt];
      end
      if (aluout_en) aluout <= alu_y;
      if (state == BRANCH && br_take) pc_r <= aluout;
      if (state == JUMP) pc_r <= {pc_r[31:28], ir[25:0], 2'b00};
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
    end
  end

  assign mem_req   = !reset && (state == FETCH || state == MEMRD || state == MEMWR);
  assign mem_we    = (state == MEMWR);
  assign mem_addr  = (state == FETCH) ? pc_r : aluout;
  assign mem_wdata = b_r;
  assign pc        = pc_r;
  assign trap      = (state == TRAP);

endmodule
